// File: rtl/aes_spi_host_seq_if.sv
// ============================================================================
// aes_spi_host_seq_if
// Request/result handshake and SPI_Main pin bundle for the AES host sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface aes_spi_host_seq_if;
  logic         req_valid;
  logic         req_ready;
  logic [255:0] req_key;
  logic [1:0]   req_key_len;
  logic         req_key_reuse;
  logic [127:0] req_pt;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_ct;
  logic         res_err;
  logic         spi_start;
  logic [257:0] spi_tx;
  logic [127:0] spi_rx;
  logic         spi_done;

  // Sequencer side
  modport slave (
    input  req_valid, req_key, req_key_len, req_key_reuse, req_pt, res_ready,
    input  spi_rx, spi_done,
    output req_ready, res_valid, res_ct, res_err, spi_start, spi_tx
  );

  // Requester / SPI environment side
  modport master (
    output req_valid, req_key, req_key_len, req_key_reuse, req_pt, res_ready,
    output spi_rx, spi_done,
    input  req_ready, res_valid, res_ct, res_err, spi_start, spi_tx
  );
endinterface

`default_nettype wire

// File: rtl/aes_spi_host_seq.sv
// ============================================================================
// aes_spi_host_seq
// Sequences key/message/readout SPI frames for one AES request, returns result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_spi_host_seq #(
  parameter int START_CYCLES   = 10,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_spi_host_seq_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(((START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES) + 1);

  localparam logic [PW-1:0] C_START    = PW'(START_CYCLES);
  localparam logic [PW-1:0] C_GAP_LAST = PW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] C_ONE      = PW'(1);
  localparam logic [TW-1:0] C_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] C_TONE     = TW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_RESULT} state_t;
  typedef enum logic [1:0] {F_KEY, F_MSG, F_RD}         frame_t;
  typedef enum logic [1:0] {P_START, P_WAIT, P_GAP}     phase_t;

  state_t         r_state;
  frame_t         r_frame;
  phase_t         r_phase;
  logic [PW-1:0]  r_pcnt;
  logic [TW-1:0]  r_tcnt;
  logic           r_done_q;
  logic           r_req_ready;
  logic           r_res_valid;
  logic [127:0]   r_res_ct;
  logic           r_res_err;
  logic           r_start;
  logic [257:0]   r_tx;
  logic [127:0]   r_pt;

  logic           w_done_edge;
  logic [255:0]   w_key_masked;

  assign w_done_edge = bus.spi_done & ~r_done_q;

  // Bits above the selected key length never reach the slave
  always_comb begin
    w_key_masked = bus.req_key;
    case (bus.req_key_len)
      2'b00:   w_key_masked = {128'b0, bus.req_key[127:0]};
      2'b01:   w_key_masked = {64'b0, bus.req_key[191:0]};
      default: w_key_masked = bus.req_key;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_frame     <= F_KEY;
      r_phase     <= P_START;
      r_pcnt      <= '0;
      r_tcnt      <= '0;
      r_done_q    <= 1'b0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_ct    <= '0;
      r_res_err   <= 1'b0;
      r_start     <= 1'b0;
      r_tx        <= '0;
      r_pt        <= '0;
    end else begin
      r_done_q <= bus.spi_done;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_pt        <= bus.req_pt;
            r_res_ct    <= '0;
            r_res_err   <= 1'b0;
            r_pcnt      <= '0;
            r_tcnt      <= '0;
            if (bus.req_key_len == 2'b11) begin
              r_state   <= S_RESULT;
              r_res_err <= 1'b1;
            end else begin
              r_state <= S_FRAME;
              r_phase <= P_START;
              r_start <= 1'b1;
              r_pcnt  <= C_ONE;
              if (bus.req_key_reuse) begin
                r_frame <= F_MSG;
                r_tx    <= {2'b00, 128'b0, bus.req_pt};
              end else begin
                r_frame <= F_KEY;
                r_tx    <= {bus.req_key_len, w_key_masked};
              end
            end
          end
        end
        S_FRAME: begin
          case (r_phase)
            P_START: begin
              if (r_pcnt == C_START) begin
                r_start <= 1'b0;
                r_phase <= P_WAIT;
                r_tcnt  <= '0;
              end else begin
                r_pcnt <= r_pcnt + C_ONE;
              end
            end
            P_WAIT: begin
              if (w_done_edge) begin
                r_phase <= P_GAP;
                r_pcnt  <= '0;
                if (r_frame == F_RD) r_res_ct <= bus.spi_rx;
              end else if (r_tcnt == C_TO_LAST) begin
                r_state   <= S_RESULT;
                r_res_err <= 1'b1;
                r_res_ct  <= '0;
                r_tx      <= '0;
              end else begin
                r_tcnt <= r_tcnt + C_TONE;
              end
            end
            P_GAP: begin
              if (r_pcnt == C_GAP_LAST) begin
                if (r_frame == F_RD) begin
                  r_state <= S_RESULT;
                  r_tx    <= '0;
                end else begin
                  r_frame <= (r_frame == F_KEY) ? F_MSG : F_RD;
                  r_tx    <= (r_frame == F_KEY) ? {2'b00, 128'b0, r_pt} : '0;
                  r_phase <= P_START;
                  r_start <= 1'b1;
                  r_pcnt  <= C_ONE;
                end
              end else begin
                r_pcnt <= r_pcnt + C_ONE;
              end
            end
            default: r_phase <= P_START;
          endcase
        end
        S_RESULT: begin
          // First cycle in RESULT raises valid; handshake only counts once valid is visible
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
          end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_ct    <= '0;
            r_res_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_ct    = r_res_ct;
  assign bus.res_err   = r_res_err;
  assign bus.spi_start = r_start;
  assign bus.spi_tx    = r_tx;

endmodule

`default_nettype wire
